hash_round_sequencer: RTL and testbench

- Initiator side of the processor ALU control interface.
- Accepts one hash-round request and issues a fixed sequence of ALU micro-ops (ctl/a/b/c), one per cycle; ALU is external and combinational.
- Collects each ALU result and returns the round value plus a target-match flag.
- Used by the signature-scan path to compute SHA-1-style round words and compare them against a stored signature word.

---
 rtl/hash_round_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_hash_round_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_round_sequencer.sv
// hash_round_sequencer
//   Initiator side of the ALU control interface. Accepts one hash-round
//   request and walks a fixed micro-op sequence through an external
//   combinational ALU:
//      FN (choose/parity) -> +h -> +k -> +w -> [compare with target] -> DONE
//   The final round word and the target-match flag are then offered on a
//   valid/ready result port.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   in_valid / in_ready         request handshake
//   mode                        0 = choose function, 1 = parity function
//   e, f, g                     round function inputs
//   h, k, w                     addends
//   target                      signature word for the compare step
//   alu_ctl, alu_a/b/c          micro-op driven to the ALU
//   alu_out, alu_zero           ALU result and zero flag
//   res_valid / res_ready       result handshake
//   res_data, res_match         round value and (res_data == target)
module hash_round_sequencer #(
   parameter bit          CMP_EN   = 1'b1,
   parameter logic [3:0]  IDLE_CTL = 4'd15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        mode,
   input  logic [31:0] e,
   input  logic [31:0] f,
   input  logic [31:0] g,
   input  logic [31:0] h,
   input  logic [31:0] k,
   input  logic [31:0] w,
   input  logic [31:0] target,
   output logic [3:0]  alu_ctl,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [31:0] alu_c,
   input  logic [31:0] alu_out,
   input  logic        alu_zero,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_match
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FN    = 3'd1,
      S_ADD_H = 3'd2,
      S_ADD_K = 3'd3,
      S_ADD_W = 3'd4,
      S_CMP   = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam logic [3:0] CTL_CHOOSE = 4'd8;
   localparam logic [3:0] CTL_PARITY = 4'd5;
   localparam logic [3:0] CTL_ADD    = 4'd2;
   localparam logic [3:0] CTL_SUB    = 4'd6;

   state_t      state_r;
   state_t      state_s;
   logic        mode_r;
   logic [31:0] e_r, f_r, g_r, h_r, k_r, w_r, target_r;
   logic [31:0] acc_r;
   logic [31:0] res_data_r;
   logic        res_match_r;

   assign in_ready  = (state_r == S_IDLE);
   assign res_valid = (state_r == S_DONE);
   assign res_data  = res_data_r;
   assign res_match = res_match_r;

   // Next-state selection and ALU micro-op drive for the current state
   always_comb begin
      state_s = state_r;
      alu_ctl = IDLE_CTL;
      alu_a   = 32'd0;
      alu_b   = 32'd0;
      alu_c   = 32'd0;
      case (state_r)
         S_IDLE: begin
            if (in_valid) begin
               state_s = S_FN;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_FN: begin
            alu_ctl = mode_r ? CTL_PARITY : CTL_CHOOSE;
            alu_a   = e_r;
            alu_b   = f_r;
            alu_c   = g_r;
            state_s = S_ADD_H;
         end
         S_ADD_H: begin
            alu_ctl = CTL_ADD;
            alu_a   = acc_r;
            alu_b   = h_r;
            state_s = S_ADD_K;
         end
         S_ADD_K: begin
            alu_ctl = CTL_ADD;
            alu_a   = acc_r;
            alu_b   = k_r;
            state_s = S_ADD_W;
         end
         S_ADD_W: begin
            alu_ctl = CTL_ADD;
            alu_a   = acc_r;
            alu_b   = w_r;
            state_s = CMP_EN ? S_CMP : S_DONE;
         end
         S_CMP: begin
            alu_ctl = CTL_SUB;
            alu_a   = acc_r;
            alu_b   = target_r;
            state_s = S_DONE;
         end
         S_DONE: begin
            if (res_ready) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_DONE;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Request operand latch, taken only on the accept edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_r   <= 1'b0;
         e_r      <= 32'd0;
         f_r      <= 32'd0;
         g_r      <= 32'd0;
         h_r      <= 32'd0;
         k_r      <= 32'd0;
         w_r      <= 32'd0;
         target_r <= 32'd0;
      end else if ((state_r == S_IDLE) && in_valid) begin
         mode_r   <= mode;
         e_r      <= e;
         f_r      <= f;
         g_r      <= g;
         h_r      <= h;
         k_r      <= k;
         w_r      <= w;
         target_r <= target;
      end
   end

   // Accumulator and result capture. The result registers are separate from
   // the accumulator so the previous result survives while the next round
   // reuses acc; they are only refreshed on the step that leads into DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r       <= 32'd0;
         res_data_r  <= 32'd0;
         res_match_r <= 1'b0;
      end else begin
         case (state_r)
            S_FN, S_ADD_H, S_ADD_K: begin
               acc_r <= alu_out;
            end
            S_ADD_W: begin
               acc_r <= alu_out;
               if (!CMP_EN) begin
                  res_data_r  <= alu_out;
                  res_match_r <= 1'b0;
               end
            end
            S_CMP: begin
               res_data_r  <= acc_r;
               res_match_r <= alu_zero;
            end
            default: begin
               acc_r <= acc_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hash_round_sequencer.sv
module tb_hash_round_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;          // 0: CMP_EN=1 instance, 1: CMP_EN=0 instance
   logic        in_valid = 1'b0;
   logic        res_ready = 1'b0;
   logic        mode = 1'b0;
   logic [31:0] e = 32'd0, f = 32'd0, g = 32'd0;
   logic [31:0] h = 32'd0, k = 32'd0, w = 32'd0, target = 32'd0;

   logic        in_valid0, in_valid1, res_ready0, res_ready1;
   logic        in_ready0, in_ready1, res_valid0, res_valid1;
   logic        res_match0, res_match1, zero0, zero1;
   logic [3:0]  ctl0, ctl1;
   logic [31:0] a0, b0, c0, a1, b1, c1, out0, out1, data0, data1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // External combinational ALU
   function automatic logic [31:0] alu_f(input logic [3:0] ctl, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c);
      case (ctl)
         4'd8:    return (a & b) | (~a & c);
         4'd5:    return a ^ b ^ c;
         4'd2:    return a + b;
         4'd6:    return a - b;
         default: return 32'd0;
      endcase
   endfunction

   assign out0 = alu_f(ctl0, a0, b0, c0);
   assign out1 = alu_f(ctl1, a1, b1, c1);
   assign zero0 = (out0 == 32'd0);
   assign zero1 = (out1 == 32'd0);

   assign in_valid0  = in_valid & ~sel;
   assign in_valid1  = in_valid & sel;
   assign res_ready0 = res_ready & ~sel;
   assign res_ready1 = res_ready & sel;

   hash_round_sequencer #(.CMP_EN(1'b1), .IDLE_CTL(4'd15)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .mode(mode),
      .e(e), .f(f), .g(g), .h(h), .k(k), .w(w), .target(target),
      .alu_ctl(ctl0), .alu_a(a0), .alu_b(b0), .alu_c(c0), .alu_out(out0), .alu_zero(zero0),
      .res_valid(res_valid0), .res_ready(res_ready0), .res_data(data0), .res_match(res_match0));

   hash_round_sequencer #(.CMP_EN(1'b0), .IDLE_CTL(4'd15)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .mode(mode),
      .e(e), .f(f), .g(g), .h(h), .k(k), .w(w), .target(target),
      .alu_ctl(ctl1), .alu_a(a1), .alu_b(b1), .alu_c(c1), .alu_out(out1), .alu_zero(zero1),
      .res_valid(res_valid1), .res_ready(res_ready1), .res_data(data1), .res_match(res_match1));

   // Observed view of the selected instance
   logic        o_in_ready, o_res_valid, o_res_match;
   logic [3:0]  o_ctl;
   logic [31:0] o_a, o_b, o_c, o_data;
   assign o_in_ready  = sel ? in_ready1  : in_ready0;
   assign o_res_valid = sel ? res_valid1 : res_valid0;
   assign o_res_match = sel ? res_match1 : res_match0;
   assign o_ctl       = sel ? ctl1 : ctl0;
   assign o_a         = sel ? a1 : a0;
   assign o_b         = sel ? b1 : b0;
   assign o_c         = sel ? c1 : c0;
   assign o_data      = sel ? data1 : data0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: round word straight from the round definition
   function automatic logic [31:0] ref_round(input logic md, input logic [31:0] re, rf, rg,
                                             input logic [31:0] rh, rk, rw);
      logic [31:0] fn;
      fn = md ? (re ^ rf ^ rg) : ((re & rf) | (~re & rg));
      return fn + rh + rk + rw;
   endfunction

   task automatic scramble_ops();
      mode = 1'($urandom_range(0, 1));
      e = $urandom; f = $urandom; g = $urandom;
      h = $urandom; k = $urandom; w = $urandom; target = $urandom;
   endtask

   // One full round on the selected instance; called at #1 after a rising edge with DUT idle
   task automatic run_round(input logic s, input logic md, input logic [31:0] re, rf, rg,
                            input logic [31:0] rh, rk, rw, rt, input int hold);
      logic [31:0] exp_d;
      logic        exp_m;
      logic [3:0]  seq [5];
      int          n;
      sel = s;
      exp_d = ref_round(md, re, rf, rg, rh, rk, rw);
      exp_m = (s == 1'b0) && (exp_d == rt);
      n = s ? 4 : 5;
      seq[0] = md ? 4'd5 : 4'd8;
      seq[1] = 4'd2; seq[2] = 4'd2; seq[3] = 4'd2; seq[4] = 4'd6;
      mode = md; e = re; f = rf; g = rg; h = rh; k = rk; w = rw; target = rt;
      in_valid = 1'b1;
      res_ready = 1'b0;
      check_val("in_ready_idle", 32'(o_in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      scramble_ops();
      for (int i = 0; i < n; i++) begin
         check_val("alu_ctl_seq", 32'(o_ctl), 32'(seq[i]));
         check_val("res_valid_busy", 32'(o_res_valid), 32'd0);
         check_val("in_ready_busy", 32'(o_in_ready), 32'd0);
         if (i == 0) begin
            check_val("fn_a", o_a, re);
            check_val("fn_b", o_b, rf);
            check_val("fn_c", o_c, rg);
         end else begin
            check_val("c_zero", o_c, 32'd0);
         end
         if (i == 4) check_val("cmp_b", o_b, rt);
         @(posedge clk); #1;
      end
      check_val("res_valid_latency", 32'(o_res_valid), 32'd1);
      check_val("res_data", o_data, exp_d);
      check_val("res_match", 32'(o_res_match), 32'(exp_m));
      check_val("done_ctl_idle", 32'(o_ctl), 32'd15);
      for (int j = 0; j < hold; j++) begin
         @(posedge clk); #1;
         check_val("hold_valid", 32'(o_res_valid), 32'd1);
         check_val("hold_data", o_data, exp_d);
         check_val("hold_match", 32'(o_res_match), 32'(exp_m));
         check_val("hold_in_ready", 32'(o_in_ready), 32'd0);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check_val("post_hs_valid", 32'(o_res_valid), 32'd0);
      check_val("post_hs_in_ready", 32'(o_in_ready), 32'd1);
      check_val("post_hs_data_kept", o_data, exp_d);
   endtask

   initial begin
      logic [31:0] q_data[$];
      logic        q_match[$];
      logic [31:0] xd;
      int          last_acc;
      int          accepts;

      // Reset state
      #2;
      check_val("rst_in_ready", 32'(in_ready0), 32'd1);
      check_val("rst_res_valid", 32'(res_valid0), 32'd0);
      check_val("rst_res_data", data0, 32'd0);
      check_val("rst_res_match", 32'(res_match0), 32'd0);
      check_val("rst_alu_ctl", 32'(ctl0), 32'd15);
      check_val("rst_alu_a", a0, 32'd0);
      check_val("rst_alu_b", b0, 32'd0);
      check_val("rst_alu_c", c0, 32'd0);
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed rounds
      run_round(1'b0, 1'b0, 32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0,
                32'd1, 32'd2, 32'd3, 32'h1234DEF6, 0);
      run_round(1'b0, 1'b1, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF,
                32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 0);
      run_round(1'b0, 1'b0, 32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0,
                32'd1, 32'd2, 32'd3, 32'd0, 4);
      run_round(1'b1, 1'b0, 32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0,
                32'd1, 32'd2, 32'd3, 32'h1234DEF6, 1);

      // Reset in the middle of a round
      sel = 1'b0;
      mode = 1'b0; e = 32'hFFFF0000; f = 32'h12345678; g = 32'h9ABCDEF0;
      h = 32'd1; k = 32'd2; w = 32'd3; target = 32'h1234DEF6;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_val("mid_ctl_add_k", 32'(ctl0), 32'd2);
      check_val("mid_b_k", b0, 32'd2);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_ctl", 32'(ctl0), 32'd15);
      check_val("mid_rst_valid", 32'(res_valid0), 32'd0);
      check_val("mid_rst_in_ready", 32'(in_ready0), 32'd1);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_val("mid_rst_no_result", 32'(res_valid0), 32'd0);
      run_round(1'b0, 1'b1, 32'h00000011, 32'h00000101, 32'h00001001,
                32'h10000000, 32'h20000000, 32'h30000000, 32'h60001111, 0);

      // Randomized rounds on both builds
      for (int r = 0; r < 16; r++) begin
         logic        rs, rm;
         logic [31:0] re, rf, rg, rh, rk, rw, rt;
         rs = (r >= 12);
         rm = 1'($urandom_range(0, 1));
         re = $urandom; rf = $urandom; rg = $urandom;
         rh = $urandom; rk = $urandom; rw = $urandom;
         rt = ($urandom_range(0, 1) == 1) ? ref_round(rm, re, rf, rg, rh, rk, rw) : 32'($urandom);
         run_round(rs, rm, re, rf, rg, rh, rk, rw, rt, int'($urandom_range(0, 3)));
      end

      // Continuous request stream: one accept every 7 cycles, busy inputs ignored
      sel = 1'b0;
      in_valid = 1'b1;
      res_ready = 1'b1;
      last_acc = -1;
      accepts = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (res_valid0) begin
            if (q_data.size() == 0) begin
               check_val("stream_unexpected_result", 32'd1, 32'd0);
            end else begin
               check_val("stream_data", data0, q_data.pop_front());
               check_val("stream_match", 32'(res_match0), 32'(q_match.pop_front()));
            end
         end
         scramble_ops();
         if (cyc[0]) target = ref_round(mode, e, f, g, h, k, w);
         if (in_ready0) begin
            if (last_acc >= 0) check_val("stream_period", 32'(cyc - last_acc), 32'd7);
            last_acc = cyc;
            accepts++;
            xd = ref_round(mode, e, f, g, h, k, w);
            q_data.push_back(xd);
            q_match.push_back(xd == target);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         if (res_valid0 && q_data.size() != 0) begin
            check_val("drain_data", data0, q_data.pop_front());
            check_val("drain_match", 32'(res_match0), 32'(q_match.pop_front()));
         end
         @(posedge clk); #1;
      end
      check_val("stream_accepts", 32'(accepts), 32'd6);
      check_val("stream_all_results", 32'(q_data.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
